bcd_updown_counter: RTL

Parametrised multi-digit BCD counter that counts up or down through decimal values with a wrap indication. Next generation of the team's single-digit BCD counter: generalised to `DIGITS` cascaded decades, with runtime direction, parallel load, and a terminal-count flag that follows the count direction. Intended for stopwatch/timer datapaths that drive the seven-segment display multiplexer.

---
 rtl/bcd_updown_counter.sv | 92 +++++++++
 1 files changed

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: DIGITS-decade BCD up/down counter with parallel load,
// direction-aware terminal count (done) and a registered wrap pulse.
// Optional build macro: BCD_COUNTER_SATURATE_EN (saturate instead of wrap).
module bcd_updown_counter #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  done,
  output logic                  wrap
);

  localparam logic [4*DIGITS-1:0] NINES = {DIGITS{4'h9}};

  logic [4*DIGITS-1:0] cnt_q, cnt_d;
  logic                wrap_q, wrap_d;
  logic [4*DIGITS-1:0] step_val;
  logic [4*DIGITS-1:0] load_clean;
  logic                carry;
  logic [3:0]          dig;

  // Ripple carry/borrow chain: a decade steps only when every lower decade is at its terminal digit
  always_comb begin
    step_val = cnt_q;
    carry    = 1'b1;
    dig      = 4'd0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dig = cnt_q[4*i +: 4];
      if (carry) begin
        if (up) begin
          step_val[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
          carry              = (dig == 4'd9);
        end else begin
          step_val[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
          carry              = (dig == 4'd0);
        end
      end
    end
  end

  // Non-decimal load digits (A-F) are forced to zero
  always_comb begin
    load_clean = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      load_clean[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd0 : load_value[4*i +: 4];
    end
  end

  // Terminal count follows the current direction
  always_comb begin
    done = up ? (cnt_q == NINES) : (cnt_q == '0);
  end

  // Next-state selection: load over enable over hold; wrap flags a step taken at terminal count
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      cnt_d = load_clean;
    end else if (enable) begin
      wrap_d = done;
`ifdef BCD_COUNTER_SATURATE_EN
      if (!done) begin
        cnt_d = step_val;
      end
`else
      // The ripple chain already rolls all-9 to all-0 and all-0 to all-9
      cnt_d = step_val;
`endif
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = cnt_q;
  assign wrap = wrap_q;

endmodule
